// File: rtl/monpro_result_unloader.sv
// monpro_result_unloader: buffers a DATA_LENGTH-bit result, then streams it
// out as DATA_WIDTH-bit words, most significant word first, on a valid/ready
// channel after getResult.
// Latency: getResult -> word 0 on res_out after one edge; each handshake
// presents the next word on the following cycle.
// Backpressure: res_out and res_out_valid hold until res_out_ready is seen.
//   Stalls may last any number of cycles.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   res_load, res_in  one-cycle parallel load of the core result
//   getResult         start streaming the buffered result
//   res_out, res_out_valid, res_out_ready   registered output word channel
//   full, busy        result buffered / streaming in progress
//   done, load_err    one-cycle pulses: last word accepted / load dropped
//
// Optional feature: define RES_CHECKSUM_EN to append one extra word after the
// data words. That word is the XOR of all data words sent.
module monpro_result_unloader #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   res_load,
  input  logic [DATA_LENGTH-1:0] res_in,
  input  logic                   getResult,
  output logic [DATA_WIDTH-1:0]  res_out,
  output logic                   res_out_valid,
  input  logic                   res_out_ready,
  output logic                   full,
  output logic                   busy,
  output logic                   done,
  output logic                   load_err
);

  localparam int WORDS = DATA_LENGTH / DATA_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, FULL, SEND, CHK} state_t;

  state_t                 state_q, state_d;
  logic [DATA_LENGTH-1:0] buf_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  res_out_d;
  logic                   valid_d, done_d, load_err_d;
  logic                   hs, last, capture, start;

  // Word k of the buffer, counted from the most significant end.
  function automatic logic [DATA_WIDTH-1:0] word_at(input logic [DATA_LENGTH-1:0] b,
                                                    input int k);
    logic [DATA_LENGTH-1:0] sh;
    sh = b >> ((WORDS - 1 - k) * DATA_WIDTH);
    return sh[DATA_WIDTH-1:0];
  endfunction

  assign hs      = res_out_valid && res_out_ready;
  assign last    = (idx_q == IDX_W'(WORDS - 1));
  assign capture = res_load && (state_q == IDLE || state_q == FULL);
  // A load in FULL takes priority over a simultaneous getResult.
  assign start   = (state_q == FULL) && getResult && !res_load;

  assign full = (state_q == FULL);
  assign busy = (state_q == SEND) || (state_q == CHK);

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      res_out       <= '0;
      res_out_valid <= 1'b0;
      done          <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      res_out       <= res_out_d;
      res_out_valid <= valid_d;
      done          <= done_d;
      load_err      <= load_err_d;
      if (capture) buf_q <= res_in;
    end
  end

`ifdef RES_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        acc_q <= '0;
    else if (start)                   acc_q <= '0;
    else if (state_q == SEND && hs)   acc_q <= acc_q ^ res_out;
  end
`endif

  // Next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (res_load) state_d = FULL;
      FULL: if (start) begin
        state_d = SEND;
        idx_d   = '0;
      end
      SEND: if (hs) begin
        if (last) begin
`ifdef RES_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = IDLE;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CHK: if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    res_out_d  = res_out;
    valid_d    = (state_d == SEND) || (state_d == CHK);
    done_d     = 1'b0;
    load_err_d = res_load && busy;
    if (start) begin
      res_out_d = word_at(buf_q, 0);
    end else if (state_q == SEND && hs) begin
      if (!last) begin
        res_out_d = word_at(buf_q, int'(idx_q) + 1);
      end else begin
`ifdef RES_CHECKSUM_EN
        // acc_q does not yet include the word accepted on this edge.
        res_out_d = acc_q ^ res_out;
`else
        done_d = 1'b1;
`endif
      end
    end else if (state_q == CHK && hs) begin
      done_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_monpro_result_unloader.sv
module tb_monpro_result_unloader;

  localparam int DW = 32;
  localparam int DL = 1024;
  localparam int W  = DL / DW;
`ifdef RES_CHECKSUM_EN
  localparam int NOUT = W + 1;
`else
  localparam int NOUT = W;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          res_load = 1'b0;
  logic [DL-1:0] res_in = '0;
  logic          getResult = 1'b0;
  logic [DW-1:0] res_out;
  logic          res_out_valid;
  logic          res_out_ready = 1'b0;
  logic          full, busy, done, load_err;

  monpro_result_unloader #(.DATA_WIDTH(DW), .DATA_LENGTH(DL)) dut (
    .clk(clk), .reset(reset), .res_load(res_load), .res_in(res_in),
    .getResult(getResult), .res_out(res_out), .res_out_valid(res_out_valid),
    .res_out_ready(res_out_ready), .full(full), .busy(busy), .done(done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            exp_err_cyc = -10;
  logic [DW-1:0] mdl [W];   // model of the buffered result
  logic [DW-1:0] stim [W];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compares every accepted word against the scoreboard queue.
  bit            exp_done = 0;
  bit            hold_pend = 0;
  logic [DW-1:0] hold_val = '0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_done  = 0;
      hold_pend = 0;
    end else begin
      bit dn;
      dn = exp_done;
      exp_done = 0;
      check("done", {63'd0, done}, {63'd0, dn});
      check("load_err", {63'd0, load_err}, {63'd0, (cyc == exp_err_cyc)});
      if (dn) check("valid_in_done_cycle", {63'd0, res_out_valid}, 64'd0);
      if (hold_pend) begin
        check("hold_valid", {63'd0, res_out_valid}, 64'd1);
        check("hold_word", {32'd0, res_out}, {32'd0, hold_val});
      end
      if (res_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, res_out}, 64'hDEAD_0000_0000);
        end else if (res_out_ready) begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", {32'd0, res_out}, {32'd0, e.word});
          if (e.last) exp_done = 1;
        end
      end
      hold_pend = res_out_valid && !res_out_ready;
      hold_val  = res_out;
    end
  end

  task automatic drive_load(input bool_mid);
    @(posedge clk); #1;
    for (int k = 0; k < W; k++) res_in[DL-1-k*DW -: DW] = stim[k];
    res_load = 1'b1;
    if (bool_mid) exp_err_cyc = cyc + 2;
    else for (int k = 0; k < W; k++) mdl[k] = stim[k];
    @(posedge clk); #1;
    res_load = 1'b0;
    if (!bool_mid) check("full_after_load", {63'd0, full}, 64'd1);
  endtask

  task automatic rand_stim();
    for (int k = 0; k < W; k++) stim[k] = $urandom;
  endtask

  // mode: 0 ready high, 1 ready toggling, 2 random ready
  // inject: 0 none, 1 load at word 10, 2 reset at word 5
  task automatic run_stream(input int mode, input int inject);
    int vc = 0, hs = 0;
    bit fin = 0, injected = 0;
    logic [DW-1:0] x = '0;
    @(posedge clk); #1;
    getResult = 1'b1;
    res_out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 0; k < W; k++) begin
      exp_q.push_back('{word: mdl[k], last: (NOUT == W) && (k == W - 1)});
      x ^= mdl[k];
    end
    if (NOUT > W) exp_q.push_back('{word: x, last: 1'b1});
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      getResult = 1'b0;
      res_load  = 1'b0;
      case (mode)
        0: res_out_ready = 1'b1;
        1: res_out_ready = ~res_out_ready;
        default: res_out_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject == 1 && hs == 10 && !injected) begin
        injected = 1;
        for (int k = 0; k < W; k++) res_in[DL-1-k*DW -: DW] = $urandom;
        res_load = 1'b1;
        exp_err_cyc = cyc + 2;
      end
      if (inject == 2 && hs == 5) begin
        reset = 1'b1;
        #1;
        check("rst_res_out", {32'd0, res_out}, 64'd0);
        check("rst_flags", {58'd0, res_out_valid, full, busy, done, load_err, 1'b0}, 64'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        res_out_ready = 1'b1;
        return;
      end
      @(negedge clk);
      if (res_out_valid) vc++;
      if (res_out_valid && res_out_ready) hs++;
      if (done) begin fin = 1; break; end
    end
    res_out_ready = 1'b0;
    check("stream_finished", {63'd0, fin}, 64'd1);
    check("full_after_done", {63'd0, full}, 64'd0);
    if (mode == 0) check("cycles_ready_high", 64'(vc), 64'(NOUT));
    if (mode == 1) check("cycles_ready_toggle", 64'(vc), 64'(2 * NOUT));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_res_out", {32'd0, res_out}, 64'd0);
    check("reset_flags", {59'd0, res_out_valid, full, busy, done, load_err}, 64'd0);
    #1 reset = 1'b0;

    // getResult while empty does nothing
    @(posedge clk); #1 getResult = 1'b1;
    @(posedge clk); #1 getResult = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("idle_getresult", {62'd0, res_out_valid, busy}, 64'd0);

    // Directed pattern, ready held high
    rand_stim();
    stim[0] = 32'h8B9496E5; stim[1] = 32'h5F06287C; stim[W-1] = 32'hA938A368;
    drive_load(0);
    run_stream(0, 0);
    // Same data, ready toggling
    drive_load(0);
    run_stream(1, 0);
    // Load dropped mid-stream
    drive_load(0);
    run_stream(0, 1);

    // Load and getResult together in FULL: load wins
    rand_stim();
    drive_load(0);
    rand_stim();
    @(posedge clk); #1;
    for (int k = 0; k < W; k++) res_in[DL-1-k*DW -: DW] = stim[k];
    res_load = 1'b1; getResult = 1'b1;
    for (int k = 0; k < W; k++) mdl[k] = stim[k];
    @(posedge clk); #1 res_load = 1'b0; getResult = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("load_wins", {62'd0, full, busy}, 64'd2);
    run_stream(0, 0);

    // Reset mid-stream, then getResult alone yields nothing
    rand_stim();
    drive_load(0);
    run_stream(0, 2);
    @(posedge clk); #1 getResult = 1'b1;
    @(posedge clk); #1 getResult = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("after_reset_getresult", {61'd0, res_out_valid, full, busy}, 64'd0);

`ifdef RES_CHECKSUM_EN
    for (int k = 0; k < W; k++) stim[k] = 32'hA5A5A5A5;
    stim[W-1] = 32'h0000FFFF;
    drive_load(0);
    run_stream(0, 0);
`endif

    // Randomized rounds with random backpressure
    for (int r = 0; r < 4; r++) begin
      rand_stim();
      drive_load(0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_stream(2, 0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
